// File: rtl/tl_pkg.sv
// Shared TileLink constants and the initiator state encoding.
package tl_pkg;
  localparam int BEAT_W        = 64;
  localparam int BEATS         = 8;
  localparam int LINE_SIZE_LG2 = 6;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_REQ,
    S_GET_RESP,
    S_PUT_DATA,
    S_PUT_ACK,
    S_RESP
  } tl_state_e;
endpackage

// File: rtl/tl_line_buf.sv
// One cache line held as 8 beat registers: bulk load, beat write, beat read, flat view.
module tl_line_buf
  import tl_pkg::*;
#(
  parameter int DATA_W = BEAT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [BEATS*DATA_W-1:0] line_i,
  input  logic                    wr_en_i,
  input  logic [2:0]              wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [2:0]              rd_idx_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [BEATS*DATA_W-1:0] line_o
);
  logic [DATA_W-1:0] mem_q [BEATS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < BEATS; k++) mem_q[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < BEATS; k++) mem_q[k] <= line_i[k*DATA_W +: DATA_W];
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

  for (genvar k = 0; k < BEATS; k++) begin : g_flat
    assign line_o[k*DATA_W +: DATA_W] = mem_q[k];
  end
endmodule

// File: rtl/tl_line_initiator.sv
// TL-UH initiator moving one 64-byte line per client request (Get + 8 beats, or 8 Puts + ack).
module tl_line_initiator
  import tl_pkg::*;
#(
  parameter int         DATA_W    = BEAT_W,
  parameter int         ADDR_W    = 64,
  parameter logic [3:0] SOURCE_ID = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [BEATS*DATA_W-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_write,
  output logic [BEATS*DATA_W-1:0] resp_rdata,
  output logic                    resp_error,
  output logic [2:0]              a_opcode,
  output logic [2:0]              a_param,
  output logic [2:0]              a_size,
  output logic [3:0]              a_source,
  output logic [ADDR_W-1:0]       a_address,
  output logic [7:0]              a_mask,
  output logic [DATA_W-1:0]       a_data,
  output logic                    a_valid,
  input  logic                    a_ready,
  input  logic [2:0]              d_opcode,
  input  logic [1:0]              d_param,
  input  logic [2:0]              d_size,
  input  logic [3:0]              d_source,
  input  logic [1:0]              d_sink,
  input  logic                    d_denied,
  input  logic [DATA_W-1:0]       d_data,
  input  logic                    d_corrupt,
  input  logic                    d_valid,
  output logic                    d_ready,
  output tl_state_e               dbg_state
);
  // Every channel (req, resp, A, D) transfers on a posedge where valid && ready;
  // a raised valid and its payload stay unchanged until that transfer happens.
  tl_state_e             state_q, state_d;
  logic [2:0]            beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d, err_q, err_d;
  logic                  a_valid_q, a_valid_d, d_ready_q, d_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [2:0]            a_opcode_q, a_opcode_d, a_size_q, a_size_d;
  logic [7:0]            a_mask_q, a_mask_d;
  logic [DATA_W-1:0]     a_data_q, a_data_d, buf_rd;
  logic                  buf_load, buf_wr;
  logic [BEATS*DATA_W-1:0] buf_line_in, buf_line;
  logic                  d_flag_err;
  logic                  unused_inputs;

  assign unused_inputs = ^{d_param, d_size, d_sink, req_addr[LINE_SIZE_LG2-1:0]};
  assign d_flag_err    = (d_source != SOURCE_ID) || d_denied || d_corrupt;

  tl_line_buf #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (buf_load),
    .line_i    (buf_line_in),
    .wr_en_i   (buf_wr),
    .wr_idx_i  (beat_cnt_q),
    .wr_data_i (d_data),
    .rd_idx_i  (beat_cnt_q + 3'd1),
    .rd_data_o (buf_rd),
    .line_o    (buf_line)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    err_d        = err_q;
    a_valid_d    = a_valid_q;
    a_opcode_d   = a_opcode_q;
    a_size_d     = a_size_q;
    a_mask_d     = a_mask_q;
    a_data_d     = a_data_q;
    d_ready_d    = d_ready_q;
    resp_valid_d = resp_valid_q;
    buf_load     = 1'b0;
    buf_line_in  = '0;
    buf_wr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[ADDR_W-1:LINE_SIZE_LG2], {LINE_SIZE_LG2{1'b0}}};
          write_d     = req_write;
          err_d       = 1'b0;
          beat_cnt_d  = 3'd0;
          a_valid_d   = 1'b1;
          a_size_d    = 3'(LINE_SIZE_LG2);
          a_mask_d    = 8'hFF;
          buf_load    = 1'b1;
          // Reads start from a cleared buffer so unfilled slots never leak old data.
          buf_line_in = req_write ? req_wdata : '0;
          if (req_write) begin
            a_opcode_d = TL_PUT_FULL;
            a_data_d   = req_wdata[DATA_W-1:0];
            state_d    = S_PUT_DATA;
          end else begin
            a_opcode_d = TL_GET;
            a_data_d   = '0;
            state_d    = S_GET_REQ;
          end
        end
      end
      S_GET_REQ: begin
        if (a_ready) begin
          a_valid_d = 1'b0;
          d_ready_d = 1'b1;
          state_d   = S_GET_RESP;
        end
      end
      S_GET_RESP: begin
        if (d_valid) begin
          buf_wr     = 1'b1;
          err_d      = err_q || d_flag_err || (d_opcode != TL_ACCESS_ACK_DATA);
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (beat_cnt_q == 3'd7) begin
            d_ready_d    = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_PUT_DATA: begin
        if (a_ready) begin
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (beat_cnt_q != 3'd7) begin
            a_data_d = buf_rd;
          end else begin
            a_valid_d = 1'b0;
            a_data_d  = '0;
            d_ready_d = 1'b1;
            // Write completions report an all-zero line.
            buf_load  = 1'b1;
            state_d   = S_PUT_ACK;
          end
        end
      end
      S_PUT_ACK: begin
        if (d_valid) begin
          err_d        = err_q || d_flag_err || (d_opcode != TL_ACCESS_ACK);
          d_ready_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= 3'd0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      a_valid_q    <= 1'b0;
      a_opcode_q   <= 3'd0;
      a_size_q     <= 3'd0;
      a_mask_q     <= 8'd0;
      a_data_q     <= '0;
      d_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      err_q        <= err_d;
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_size_q     <= a_size_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      d_ready_q    <= d_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_write = write_q;
  assign resp_error = err_q;
  assign resp_rdata = buf_line;
  assign a_opcode   = a_opcode_q;
  assign a_param    = 3'd0;
  assign a_size     = a_size_q;
  assign a_source   = SOURCE_ID;
  assign a_address  = addr_q;
  assign a_mask     = a_mask_q;
  assign a_data     = a_data_q;
  assign a_valid    = a_valid_q;
  assign d_ready    = d_ready_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_tl_line_initiator.sv
// Randomised bench: TL-UH memory responder, line-level reference memory and response scoreboard.
module tb_tl_line_initiator;
  import tl_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  src;
    logic        den;
    logic        cor;
    logic [63:0] data;
  } dbeat_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [63:0]  req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         req_ready, resp_valid, resp_write, resp_error;
  logic         resp_ready = 1'b0;
  logic [511:0] resp_rdata;
  logic [2:0]   a_opcode, a_param, a_size;
  logic [3:0]   a_source;
  logic [63:0]  a_address, a_data;
  logic [7:0]   a_mask;
  logic         a_valid;
  logic         a_ready = 1'b0;
  logic [2:0]   d_opcode = '0, d_size = '0;
  logic [1:0]   d_param = '0, d_sink = '0;
  logic [3:0]   d_source = '0;
  logic         d_denied = 1'b0, d_corrupt = 1'b0, d_valid = 1'b0;
  logic [63:0]  d_data = '0;
  logic         d_ready;
  tl_state_e    dbg_state;

  tl_line_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready),
    .dbg_state(dbg_state)
  );

  // scoreboard state and reference model
  int vectors = 0;
  int miscompares = 0;
  logic [513:0] exp_q[$];
  logic [148:0] a_exp_q[$];
  dbeat_t       dq[$];
  bit [63:0]    ref_mem [bit [63:0]];
  bit [63:0]    slv_mem [bit [63:0]];

  int ar_mode = 0, d_rand = 0, resp_hold = 0, resp_wait = 0;
  int inj_beat = -1, inj_kind = 0, put_cnt = 0;
  logic [63:0] put_buf [8];
  logic [63:0] put_addr = '0;
  logic        d_fired = 1'b1, a_stall = 1'b0, r_stall = 1'b0;
  logic [148:0] a_stall_val = '0;
  logic [513:0] r_val = '0;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit [63:0] ref_rd(input bit [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a >> 3);
  endfunction

  function automatic bit [63:0] slv_rd(input bit [63:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : (a >> 3);
  endfunction

  function automatic dbeat_t inject(input dbeat_t b, input int kind);
    dbeat_t r = b;
    case (kind)
      0:       r.den = 1'b1;
      1:       r.cor = 1'b1;
      2:       r.op  = b.op ^ 3'b010;
      default: r.src = 4'd9;
    endcase
    return r;
  endfunction

  // responder: drives a_ready / D channel / resp_ready on negedge, observes transfers 1ns later
  always @(negedge clk) begin
    dbeat_t b;
    logic [148:0] a_pay;
    case (ar_mode)
      0:       a_ready = 1'b1;
      1:       a_ready = ~a_ready;
      default: a_ready = 1'($urandom_range(0, 1));
    endcase
    if (!(d_valid && !d_fired)) begin
      if (dq.size() > 0 && (d_rand == 0 || $urandom_range(0, 2) != 0)) begin
        d_valid = 1'b1; d_opcode = dq[0].op; d_source = dq[0].src;
        d_denied = dq[0].den; d_corrupt = dq[0].cor; d_data = dq[0].data;
      end else begin
        d_valid = 1'b0;
      end
    end
    d_fired = 1'b0;
    resp_ready = (resp_wait == 0);
    if (resp_valid && resp_wait > 0) resp_wait--;
    #1;
    a_pay = {a_opcode, a_param, a_size, a_source, a_mask, a_address, a_data};
    if (rst) begin
      dq.delete(); a_exp_q.delete(); put_cnt = 0; a_stall = 1'b0; d_fired = 1'b1;
    end else begin
      if (req_valid && req_ready) resp_wait = resp_hold;
      if (a_stall) check("a_hold", 640'({a_valid, a_pay}), 640'({1'b1, a_stall_val}));
      if (a_valid && a_ready) begin
        a_stall = 1'b0;
        if (a_exp_q.size() == 0) check("a_extra_beat", 640'(a_pay), 640'(0));
        else check("a_beat", 640'(a_pay), 640'(a_exp_q.pop_front()));
        if (a_opcode == TL_GET) begin
          for (int k = 0; k < 8; k++) begin
            b = '{op: TL_ACCESS_ACK_DATA, src: 4'd0, den: 1'b0, cor: 1'b0,
                  data: slv_rd(a_address + 64'(8*k))};
            if (k == inj_beat) b = inject(b, inj_kind);
            dq.push_back(b);
          end
        end else begin
          if (put_cnt == 0) put_addr = a_address;
          put_buf[put_cnt] = a_data;
          put_cnt++;
          if (put_cnt == 8) begin
            for (int k = 0; k < 8; k++) slv_mem[put_addr + 64'(8*k)] = put_buf[k];
            b = '{op: TL_ACCESS_ACK, src: 4'd0, den: 1'b0, cor: 1'b0, data: 64'd0};
            if (inj_beat == 0) b = inject(b, inj_kind);
            dq.push_back(b);
            put_cnt = 0;
          end
        end
      end else if (a_valid) begin
        a_stall = 1'b1; a_stall_val = a_pay;
      end else begin
        a_stall = 1'b0;
      end
      if (d_valid && d_ready) begin
        void'(dq.pop_front());
        d_fired = 1'b1;
      end
    end
  end

  // response monitor: pops the scoreboard on every completion handshake
  always @(negedge clk) begin
    logic [513:0] cur;
    #1;
    cur = {resp_write, resp_error, resp_rdata};
    if (rst) begin
      r_stall = 1'b0;
    end else if (resp_valid) begin
      if (r_stall) begin
        check("resp_hold", 640'(cur), 640'(r_val));
        check("req_ready_during_resp", 640'(req_ready), 640'(0));
      end
      if (resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 640'(cur), 640'(0));
        else check("resp", 640'(cur), 640'(exp_q.pop_front()));
        r_stall = 1'b0;
      end else begin
        r_stall = 1'b1; r_val = cur;
      end
    end else begin
      if (r_stall) check("resp_dropped", 640'(resp_valid), 640'(1));
      r_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input logic wr, input logic [63:0] addr, input logic [511:0] wd);
    logic [63:0]  la;
    logic [511:0] exp_rd;
    int n;
    la = addr & ~64'h3F;
    exp_rd = '0;
    for (int k = 0; k < 8; k++) begin
      if (wr) begin
        a_exp_q.push_back({TL_PUT_FULL, 3'd0, 3'd6, 4'd0, 8'hFF, la, wd[64*k +: 64]});
        ref_mem[la + 64'(8*k)] = wd[64*k +: 64];
      end else begin
        exp_rd[64*k +: 64] = ref_rd(la + 64'(8*k));
      end
    end
    if (!wr) a_exp_q.push_back({TL_GET, 3'd0, 3'd6, 4'd0, 8'hFF, la, 64'd0});
    exp_q.push_back({wr, inj_beat >= 0, exp_rd});
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("req_ready_timeout", 640'(0), 640'(1));
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_txn();
    int n = 0;
    while (!(exp_q.size() == 0 && req_ready) && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      check("txn_timeout", 640'(0), 640'(1));
      exp_q.delete(); a_exp_q.delete();
    end
    check("a_beats_outstanding", 640'(a_exp_q.size()), 640'(0));
    inj_beat = -1;
    resp_hold = 0;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] wd;
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] wd;
    logic [63:0]  ra;
    int n;
    logic wr;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", 640'({req_ready, a_valid, d_ready, resp_valid, resp_error}), 640'(5'b10000));
    check("rst_rdata", 640'(resp_rdata), 640'(0));
    check("rst_a_payload", 640'({a_opcode, a_size, a_mask, a_address, a_data}), 640'(0));
    check("rst_state", 640'(dbg_state), 640'(S_IDLE));
    rst = 1'b0;

    // zero-wait read: memory word k of line 0x1C0 holds 0x38+k
    ar_mode = 0; d_rand = 0;
    issue(1'b0, 64'h1C0, '0); finish_txn();

    // write with a_ready toggling, then read the line back
    ar_mode = 1;
    for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'hA0 + 64'(k);
    issue(1'b1, 64'h40, wd); finish_txn();
    ar_mode = 0;
    issue(1'b0, 64'h40, '0); finish_txn();

    // denied on beat 3, then a clean read
    d_rand = 1; inj_beat = 3; inj_kind = 0;
    issue(1'b0, 64'h200, '0); finish_txn();
    issue(1'b0, 64'h200, '0); finish_txn();

    // completion held off for five cycles
    resp_hold = 5;
    issue(1'b0, 64'h40, '0); finish_txn();

    // reset during Put beat 4
    d_rand = 0; ar_mode = 0;
    issue(1'b1, 64'h3000, rand_line());
    n = 0;
    while (put_cnt != 4 && n < 100) begin @(negedge clk); n++; end
    check("reach_put_beat4", 640'(put_cnt), 640'(4));
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 8; k++) ref_mem.delete(64'h3000 + 64'(8*k));
    @(negedge clk); #1;
    check("mid_rst_a_valid", 640'(a_valid), 640'(0));
    check("mid_rst_state", 640'(dbg_state), 640'(S_IDLE));
    check("mid_rst_req_ready", 640'(req_ready), 640'(1));
    rst = 1'b0;
    issue(1'b0, 64'h3000, '0); finish_txn();

    // unaligned address is forced to its line base
    wd = rand_line();
    issue(1'b1, 64'h1234_5677, wd); finish_txn();
    issue(1'b0, 64'h1234_5677, '0); finish_txn();

    // randomised traffic over a small address pool so reads hit earlier writes
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra = 64'(($urandom_range(0, 7)) * 64 + 64'h8000);
      ar_mode = $urandom_range(0, 2);
      d_rand = $urandom_range(0, 1);
      resp_hold = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        inj_beat = wr ? 0 : $urandom_range(0, 7);
        inj_kind = $urandom_range(0, 3);
      end
      issue(wr, ra, rand_line());
      finish_txn();
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
